// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key controller.
package ps2_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Decoder states: which prefix bytes have been seen so far
  typedef enum logic [1:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0
  } ps2_state_e;

  // Queued key event, packed as {brk, ext, code}
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event queue: power-of-two depth, pointers with an extra wrap bit.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status flags from the pointers; a pop on empty is ignored, a push on full needs a pop
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // Head reads as zero while empty so the output is defined after reset
    rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder with typematic repeat filter, event queue and counters.
import ps2_pkg::*;

module ps2_key_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       evt_valid,
  output logic [9:0] evt_data,
  input  logic       evt_ready,
  output logic [7:0] key_cnt,
  output logic       ovf,
  input  logic       ovf_clr
);

  ps2_state_e state_q, state_d;
  logic       raw_emit;
  ps2_evt_t   raw_evt;
  logic       emit_q, emit_d;
  ps2_evt_t   evt_q, evt_d;
  logic       held_q, held_d;
  logic [8:0] held_key_q, held_key_d;
  logic       key_match;
  logic [7:0] key_cnt_q, key_cnt_d;
  logic       ovf_q, ovf_d;
  logic       is_pfx;
  logic       fifo_full, fifo_empty;
  logic       pop_ok, push_ok, drop;
  logic [9:0] fifo_rdata;

  // Prefix decoder: next state and the raw event formed by the current byte
  always_comb begin
    state_d  = state_q;
    raw_emit = 1'b0;
    raw_evt  = '{brk: 1'b0, ext: 1'b0, code: rx_data};
    is_pfx   = (rx_data == PS2_PFX_EXT) || (rx_data == PS2_PFX_BRK);
    if (rx_err) begin
      state_d = StIdle;
    end else if (rx_valid) begin
      case (state_q)
        StIdle: begin
          if (rx_data == PS2_PFX_EXT)      state_d = StE0;
          else if (rx_data == PS2_PFX_BRK) state_d = StF0;
          else                             raw_emit = 1'b1;
        end
        StE0: begin
          if (rx_data == PS2_PFX_BRK) begin
            state_d = StE0F0;
          end else if (rx_data != PS2_PFX_EXT) begin
            state_d     = StIdle;
            raw_emit    = 1'b1;
            raw_evt.ext = 1'b1;
          end
        end
        StF0: begin
          // A second prefix here is a protocol error: drop silently
          state_d     = StIdle;
          raw_emit    = !is_pfx;
          raw_evt.brk = 1'b1;
        end
        StE0F0: begin
          state_d     = StIdle;
          raw_emit    = !is_pfx;
          raw_evt.brk = 1'b1;
          raw_evt.ext = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Repeat filter and held-key tracking
  always_comb begin
    held_d     = held_q;
    held_key_d = held_key_q;
    emit_d     = 1'b0;
    evt_d      = raw_evt;
    key_match  = (held_key_q == {raw_evt.ext, raw_evt.code});
    if (raw_emit) begin
      if (raw_evt.brk) begin
        emit_d = 1'b1;
        if (key_match) held_d = 1'b0;
      end else if ((REPEAT_FILTER != 0) && held_q && key_match) begin
        emit_d = 1'b0;
      end else begin
        emit_d     = 1'b1;
        held_d     = 1'b1;
        held_key_d = {raw_evt.ext, raw_evt.code};
      end
    end
  end

  // Queue handshake, break counter and sticky overflow
  always_comb begin
    pop_ok    = evt_ready && !fifo_empty;
    push_ok   = emit_q && (!fifo_full || pop_ok);
    drop      = emit_q && fifo_full && !pop_ok;
    key_cnt_d = key_cnt_q + ((push_ok && evt_q.brk) ? 8'd1 : 8'd0);
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // State registers; the decoded event is staged one cycle before entering the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      emit_q     <= 1'b0;
      evt_q      <= '0;
      held_q     <= 1'b0;
      held_key_q <= '0;
      key_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      emit_q     <= emit_d;
      evt_q      <= evt_d;
      held_q     <= held_d;
      held_key_q <= held_key_d;
      key_cnt_q  <= key_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata (evt_q),
    .pop   (pop_ok),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_data  = fifo_rdata;
  assign key_cnt   = key_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, event queue depth (power of two, >=2).
REQ-002 Parameter: REPEAT_FILTER, default 1, drops typematic repeats when 1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle pulse: a checked scan-code byte is available from the PS/2 receiver.
REQ-006 rx_data  input  8  scan-code byte; qualified by rx_valid.
REQ-007 rx_err  input  1  one-cycle pulse: receiver framing/parity error.
REQ-008 evt_valid  output  1  event queue non-empty.
REQ-009 evt_data  output  10  head event {brk, ext, code[7:0]}.
REQ-010 evt_ready  input  1  consumer pops head when evt_valid & evt_ready.
REQ-011 key_cnt  output  8  number of accepted break (key-release) events, wraps.
REQ-012 ovf  output  1  sticky: an event was dropped because the queue was full.
REQ-013 ovf_clr  input  1  clears ovf.

Function
REQ-014 Decoder FSM states: IDLE, E0, F0, E0F0; it advances only on rx_valid.
REQ-015 IDLE: byte E0 -> E0; byte F0 -> F0; any other byte -> emit {0,0,byte}, stay in IDLE.
REQ-016 E0: byte F0 -> E0F0; byte E0 -> stay in E0; other byte -> emit {0,1,byte}, go to IDLE.
REQ-017 F0: other byte -> emit {1,0,byte}, go to IDLE; byte E0 or F0 -> protocol error, go to IDLE, emit nothing.
REQ-018 E0F0: other byte -> emit {1,1,byte}, go to IDLE; byte E0 or F0 -> go to IDLE, emit nothing.
REQ-019 rx_err forces the FSM to IDLE in the same cycle and discards any pending prefix; rx_err takes priority over a simultaneous rx_valid.
REQ-020 Held-key register {ext, code} plus a held flag; a make sets them, a break whose {ext, code} matches clears the held flag.
REQ-021 With REPEAT_FILTER=1, a make matching the held key while the held flag is set is dropped: not queued, no ovf.
REQ-022 Emitted events are written to the FIFO on the edge after the final rx_valid byte and appear on evt_valid/evt_data one cycle later (total latency 2 cycles from the byte's rx_valid).
REQ-023 The FIFO is first-in first-out; evt_data shows the head and is stable while evt_valid is high and evt_ready is low.
REQ-024 Full FIFO with push and no pop: the event is dropped, ovf is set, and key_cnt is not incremented.
REQ-025 Full FIFO with simultaneous push and pop: both are performed and there is no overflow.
REQ-026 Empty FIFO with simultaneous push and pop request: the pop is ignored (evt_valid low) and the push is performed.
REQ-027 key_cnt increments by 1 modulo 256 for each break event actually written to the FIFO.
REQ-028 ovf_clr clears ovf; a drop in the same cycle wins (ovf stays 1).
REQ-029 FIFO pointers carry one extra wrap bit; full/empty are derived from the pointers, with no separate occupancy counter.

Reset
REQ-030 Asserting reset immediately (asynchronously) puts the FSM in IDLE and sets FIFO pointers = 0, evt_valid = 0, evt_data = 0, key_cnt = 0, ovf = 0, held flag = 0.
REQ-031 Reset asserted mid-sequence (after E0/F0) discards the prefix; the first byte after reset release is decoded from IDLE.

Structure
REQ-032 Package ps2_pkg holds: the FSM state enum, the event struct typedef {brk, ext, code}, and constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
REQ-033 The queue is the single sub-module ps2_evt_fifo (parameterised depth/width, push/pop/full/empty); decode, repeat filter and counters stay in ps2_key_ctrl.

Verification
REQ-034 Bytes 1C, F0, 1C -> events {0,0,1C}, {1,0,1C}; key_cnt 0->1.
REQ-035 Bytes E0, 75, E0, F0, 75 -> events {0,1,75}, {1,1,75}; key_cnt 1.
REQ-036 Bytes 1C, 1C, 1C, F0, 1C with REPEAT_FILTER=1 -> only two events queued; with REPEAT_FILTER=0 -> four.
REQ-037 evt_ready held 0, 9 distinct makes (FIFO_DEPTH=8) -> 8 queued, ovf=1; ovf_clr -> ovf=0; then 8 pops return the codes in order.
REQ-038 Bytes F0, then rx_err, then 1C -> single event {0,0,1C}; also reset asserted after E0, then 75 -> {0,0,75}.
REQ-039 Full FIFO, push and pop in the same cycle -> occupancy stays 8, ovf stays 0, head advances.
